// File: rtl/seg7_anim_sequencer.sv
// Seven-segment animation engine: tick divider, frame sequencer across four built-in
// animations (decimal, hex, ring spin, figure-8), auto/manual mode cycling, pause/step, reverse.
module seg7_anim_sequencer #(
  parameter int CNT_WIDTH    = 24,
  parameter int DEFAULT_DIV  = 10_000_000,
  parameter int SHIFT        = 10,
  parameter int REPEATS      = 2,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] div_sel,
  input  logic [1:0] mode_sel,
  input  logic       auto_en,
  input  logic       pause,
  input  logic       step,
  input  logic       reverse,
  output logic [6:0] seg_out,
  output logic       dp,
  output logic [3:0] frame,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {
    MODE_DEC  = 2'd0,
    MODE_HEX  = 2'd1,
    MODE_RING = 2'd2,
    MODE_FIG8 = 2'd3
  } mode_e;

  localparam int PW = (REPEATS < 2) ? 1 : $clog2(REPEATS + 1);
  localparam int WW = CNT_WIDTH + SHIFT + 8;
  localparam logic [CNT_WIDTH-1:0] DEF_CMP  = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [PW-1:0]        LAST_PASS = PW'(REPEATS - 1);
  localparam logic [6:0]           INV_SEG  = {7{COMMON_ANODE}};

  function automatic logic [3:0] last_frame(input mode_e m);
    case (m)
      MODE_DEC:  return 4'd9;
      MODE_HEX:  return 4'd15;
      MODE_RING: return 4'd5;
      default:   return 4'd7;
    endcase
  endfunction

  function automatic logic [6:0] decode(input mode_e m, input logic [3:0] f);
    logic [6:0] s;
    s = 7'h00;
    case (m)
      MODE_DEC, MODE_HEX: begin
        case (f)
          4'd0:  s = 7'h3F;
          4'd1:  s = 7'h06;
          4'd2:  s = 7'h5B;
          4'd3:  s = 7'h4F;
          4'd4:  s = 7'h66;
          4'd5:  s = 7'h6D;
          4'd6:  s = 7'h7D;
          4'd7:  s = 7'h07;
          4'd8:  s = 7'h7F;
          4'd9:  s = 7'h6F;
          4'd10: s = 7'h77;
          4'd11: s = 7'h7C;
          4'd12: s = 7'h39;
          4'd13: s = 7'h5E;
          4'd14: s = 7'h79;
          default: s = 7'h71;
        endcase
        // Decimal shares the hex table but must blank the A-F codes it never reaches.
        if (m == MODE_DEC && f > 4'd9) s = 7'h00;
      end
      MODE_RING: begin
        case (f)
          4'd0: s = 7'h01;
          4'd1: s = 7'h02;
          4'd2: s = 7'h04;
          4'd3: s = 7'h08;
          4'd4: s = 7'h10;
          4'd5: s = 7'h20;
          default: s = 7'h00;
        endcase
      end
      default: begin
        case (f)
          4'd0: s = 7'h01;
          4'd1: s = 7'h02;
          4'd2: s = 7'h40;
          4'd3: s = 7'h10;
          4'd4: s = 7'h08;
          4'd5: s = 7'h04;
          4'd6: s = 7'h40;
          4'd7: s = 7'h20;
          default: s = 7'h00;
        endcase
      end
    endcase
    return s;
  endfunction

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [3:0]           frame_q;
  mode_e                mode_q;
  logic [PW-1:0]        pass_q;
  logic                 dp_state_q;
  logic                 step_q;
  logic                 tick_q;
  logic [6:0]           seg_q;
  logic                 dp_q;

  logic [CNT_WIDTH-1:0] cmp;
  logic                 step_rise;
  logic                 advance;
  logic [3:0]           last;
  logic                 at_end;
  logic [3:0]           frame_step;
  logic                 manual_switch;
  logic                 auto_switch;
  mode_e                next_mode;
  logic [3:0]           next_start;

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    cmp           = (div_sel == 8'd0) ? DEF_CMP : CNT_WIDTH'(WW'(div_sel) << SHIFT);
    step_rise     = step & ~step_q;
    advance       = (tick_q & ~pause) | (pause & step_rise);
    last          = last_frame(mode_q);
    at_end        = reverse ? (frame_q == 4'd0) : (frame_q == last);
    frame_step    = frame_q;
    if (reverse) frame_step = at_end ? last : frame_q - 4'd1;
    else         frame_step = at_end ? 4'd0 : frame_q + 4'd1;
    manual_switch = !auto_en && (mode_sel != mode_q);
    auto_switch   = auto_en && at_end && (pass_q >= LAST_PASS);
    next_mode     = manual_switch ? mode_e'(mode_sel) : mode_e'(mode_q + 2'd1);
    next_start    = reverse ? last_frame(next_mode) : 4'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      frame_q    <= 4'd0;
      mode_q     <= MODE_DEC;
      pass_q     <= '0;
      dp_state_q <= 1'b0;
      step_q     <= 1'b0;
      tick_q     <= 1'b0;
      seg_q      <= INV_SEG;
      dp_q       <= COMMON_ANODE;
    end else if (!ena) begin
      tick_q <= 1'b0;
    end else begin
      step_q <= step;
      // >= rather than == so lowering the compare below the running count still wraps.
      if (cnt_q >= cmp) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
        tick_q <= 1'b0;
      end

      if (manual_switch) begin
        mode_q  <= next_mode;
        frame_q <= next_start;
        pass_q  <= '0;
      end else if (advance) begin
        if (at_end) begin
          dp_state_q <= ~dp_state_q;
          if (auto_switch) begin
            mode_q  <= next_mode;
            frame_q <= next_start;
            pass_q  <= '0;
          end else begin
            frame_q <= frame_step;
            pass_q  <= pass_q + PW'(1);
          end
        end else begin
          frame_q <= frame_step;
        end
      end

      seg_q <= decode(mode_q, frame_q) ^ INV_SEG;
      dp_q  <= dp_state_q ^ COMMON_ANODE;
    end
  end

  assign seg_out = seg_q;
  assign dp      = dp_q;
  assign frame   = frame_q;
  assign mode    = mode_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_seg7_anim_sequencer.sv
// Directed bench for seg7_anim_sequencer with a short divider (DEFAULT_DIV=3, SHIFT=0).
// Outputs are sampled on the falling edge; inputs also change there.
module tb_seg7_anim_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] div_sel;
  logic [1:0] mode_sel;
  logic       auto_en;
  logic       pause;
  logic       step;
  logic       reverse;
  logic [6:0] seg_out;
  logic       dp;
  logic [3:0] frame;
  logic [1:0] mode;
  logic       tick;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] DEC_SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam int         RING_REV_FRAME [6] = '{4, 3, 2, 1, 0, 5};
  localparam logic [6:0] RING_REV_SEG [6]   = '{7'h10, 7'h08, 7'h04, 7'h02, 7'h01, 7'h20};

  seg7_anim_sequencer #(
    .CNT_WIDTH   (8),
    .DEFAULT_DIV (3),
    .SHIFT       (0),
    .REPEATS     (2),
    .COMMON_ANODE(1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .div_sel (div_sel),
    .mode_sel(mode_sel),
    .auto_en (auto_en),
    .pause   (pause),
    .step    (step),
    .reverse (reverse),
    .seg_out (seg_out),
    .dp      (dp),
    .frame   (frame),
    .mode    (mode),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tick) return;
    end
    check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick_period(output int p);
    p = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (tick) begin
        p = i;
        return;
      end
    end
  endtask

  int  p;
  logic saw_tick;
  logic frame_moved;

  initial begin
    rst_n = 1'b0; ena = 1'b1; div_sel = 8'd0; mode_sel = 2'd0;
    auto_en = 1'b0; pause = 1'b0; step = 1'b0; reverse = 1'b0;

    // Reset state
    #13;
    check("rst_seg", seg_out, 7'h00);
    check("rst_dp", dp, 1'b0);
    check("rst_frame", frame, 4'd0);
    check("rst_mode", mode, 2'd0);
    check("rst_tick", tick, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Decimal count, seg lags frame by one clock, wrap toggles dp
    for (int k = 1; k <= 10; k++) begin
      wait_tick();
      @(negedge clk);
      check("dec_frame", frame, k % 10);
      check("dec_seg_lag", seg_out, DEC_SEG[k - 1]);
      @(negedge clk);
      check("dec_seg", seg_out, DEC_SEG[k % 10]);
    end
    check("dec_dp_wrap", dp, 1'b1);
    wait_tick();
    tick_period(p);
    check("period_def", p, 4);

    // div_sel=1 -> compare 1 -> tick every 2 clocks
    div_sel = 8'd1;
    tick_period(p);
    check("period_sel1_a", p, 2);
    tick_period(p);
    check("period_sel1_b", p, 2);

    // Lower compare below the running count: immediate wrap
    div_sel = 8'd20;
    repeat (8) @(negedge clk);
    div_sel = 8'd0;
    @(negedge clk);
    check("lower_cmp_tick", tick, 1'b1);
    tick_period(p);
    check("lower_cmp_period", p, 4);

    // Ring in reverse; mode switch beats the simultaneous tick
    wait_tick();
    mode_sel = 2'd2; reverse = 1'b1;
    @(negedge clk);
    check("ring_mode", mode, 2'd2);
    check("ring_start", frame, 4'd5);
    @(negedge clk);
    check("ring_start_seg", seg_out, 7'h20);
    for (int k = 0; k < 6; k++) begin
      wait_tick();
      @(negedge clk);
      check("ring_rev_frame", frame, RING_REV_FRAME[k]);
      @(negedge clk);
      check("ring_rev_seg", seg_out, RING_REV_SEG[k]);
    end
    wait_tick();
    mode_sel = 2'd3;
    @(negedge clk);
    check("fig8_mode", mode, 2'd3);
    check("fig8_start", frame, 4'd7);
    @(negedge clk);
    check("fig8_seg", seg_out, 7'h20);
    wait_tick();
    reverse = 1'b0;
    @(negedge clk);
    check("rev_off_frame", frame, 4'd0);
    @(negedge clk);
    check("rev_off_seg", seg_out, 7'h01);

    // Auto mode cycling, REPEATS=2, tick every 3 clocks
    @(negedge clk); rst_n = 1'b0;
    auto_en = 1'b1; reverse = 1'b0; mode_sel = 2'd0; div_sel = 8'd2;
    @(negedge clk); rst_n = 1'b1;
    repeat (19) wait_tick();
    @(negedge clk);
    check("auto_pre_mode", mode, 2'd0);
    check("auto_pre_frame", frame, 4'd9);
    check("auto_pre_dp", dp, 1'b1);
    wait_tick();
    @(negedge clk);
    check("auto_hex_mode", mode, 2'd1);
    check("auto_hex_frame", frame, 4'd0);
    @(negedge clk);
    check("auto_hex_seg", seg_out, 7'h3F);
    repeat (32) wait_tick();
    @(negedge clk);
    check("auto_ring_mode", mode, 2'd2);
    repeat (12) wait_tick();
    @(negedge clk);
    check("auto_fig8_mode", mode, 2'd3);
    repeat (16) wait_tick();
    @(negedge clk);
    check("auto_wrap_mode", mode, 2'd0);
    check("auto_wrap_frame", frame, 4'd0);

    // Pause and single-step
    auto_en = 1'b0; pause = 1'b1;
    repeat (3) wait_tick();
    @(negedge clk);
    check("pause_frozen", frame, 4'd0);
    repeat (3) begin
      step = 1'b1; @(negedge clk);
      step = 1'b0; @(negedge clk);
    end
    check("step3_frame", frame, 4'd3);
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check("step_held_frame", frame, 4'd4);
    check("step_held_seg", seg_out, 7'h66);

    // Asynchronous reset between edges
    pause = 1'b0;
    repeat (2) wait_tick();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg_out, 7'h00);
    check("async_rst_frame", frame, 4'd0);
    check("async_rst_mode", mode, 2'd0);

    // ena low freezes everything, including a pending tick
    div_sel = 8'd0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) wait_tick();
    ena = 1'b0;
    saw_tick = 1'b0; frame_moved = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tick) saw_tick = 1'b1;
      if (frame != 4'd2) frame_moved = 1'b1;
    end
    check("ena_tick", saw_tick, 1'b0);
    check("ena_frame_moved", frame_moved, 1'b0);
    check("ena_frame", frame, 4'd2);
    check("ena_seg", seg_out, 7'h5B);
    ena = 1'b1;
    wait_tick();
    @(negedge clk);
    check("ena_resume_frame", frame, 4'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
